// File: rtl/lru_state_array.sv
// rtl/lru_state_array.sv - per-set LRU age-counter rows with init sweep and 2-stage read-modify-write
module lru_state_array #(
  parameter int WAY  = 4,
  parameter int SETS = 64
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  input  logic [$clog2(SETS)-1:0]               i_req_set,
  input  logic                                  i_req_hit,
  input  logic [$clog2(WAY)-1:0]                i_req_way,
  output logic                                  o_rsp_valid,
  output logic [$clog2(SETS)-1:0]               o_rsp_set,
  output logic [$clog2(WAY)-1:0]                o_rsp_way,
  output logic [WAY*$clog2(WAY)-1:0]            o_rsp_tags,
  output logic                                  o_init_done
);

  localparam int SINGLE_TAG_LENGTH = $clog2(WAY);
  localparam int TAG_LENGTH        = WAY * SINGLE_TAG_LENGTH;
  localparam int SET_BITS          = $clog2(SETS);
  localparam int STL               = SINGLE_TAG_LENGTH;

  function automatic logic [TAG_LENGTH-1:0] init_row_f();
    logic [TAG_LENGTH-1:0] r;
    r = '0;
    for (int i = 0; i < WAY; i++) begin
      r[(WAY-1-i)*STL +: STL] = STL'(WAY-1-i);
    end
    return r;
  endfunction

  localparam logic [TAG_LENGTH-1:0] INIT_ROW = init_row_f();

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q;
  logic [SET_BITS-1:0]   init_cnt_q;
  logic [TAG_LENGTH-1:0] mem_q [SETS];

  logic                  a_valid_q;
  logic [SET_BITS-1:0]   a_set_q;
  logic                  a_hit_q;
  logic [STL-1:0]        a_way_q;
  logic [TAG_LENGTH-1:0] a_row_q;

  logic                  accept;
  logic [TAG_LENGTH-1:0] rd_row;
  logic [STL-1:0]        tgt_way;
  logic [STL-1:0]        hold_cnt;
  logic [STL-1:0]        cnt;
  logic [TAG_LENGTH-1:0] new_row_d;

  assign accept = i_req_valid & o_req_ready;

  // Stage B: pick target way, promote it to MRU, age the ways that were younger.
  always_comb begin
    tgt_way = a_way_q;
    if (!a_hit_q) begin
      tgt_way = '0;
      for (int i = WAY-1; i >= 0; i--) begin
        if (a_row_q[(WAY-1-i)*STL +: STL] == '0) tgt_way = STL'(i);
      end
    end
    hold_cnt = '0;
    for (int i = 0; i < WAY; i++) begin
      if (STL'(i) == tgt_way) hold_cnt = a_row_q[(WAY-1-i)*STL +: STL];
    end
    new_row_d = a_row_q;
    cnt       = '0;
    for (int i = 0; i < WAY; i++) begin
      cnt = a_row_q[(WAY-1-i)*STL +: STL];
      if (STL'(i) == tgt_way) begin
        new_row_d[(WAY-1-i)*STL +: STL] = STL'(WAY-1);
      end else if (cnt > hold_cnt) begin
        new_row_d[(WAY-1-i)*STL +: STL] = cnt - STL'(1);
      end
    end
  end

  // A same-set access right behind stage B must see B's row, not the stale array.
  assign rd_row = (a_valid_q && (a_set_q == i_req_set)) ? new_row_d : mem_q[i_req_set];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      o_req_ready <= 1'b0;
      o_init_done <= 1'b0;
      a_valid_q   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_set   <= '0;
      o_rsp_way   <= '0;
      o_rsp_tags  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + SET_BITS'(1);
          if (init_cnt_q == SET_BITS'(SETS-1)) begin
            state_q     <= S_RUN;
            o_req_ready <= 1'b1;
            o_init_done <= 1'b1;
          end
        end
        default: ;
      endcase

      a_valid_q <= accept;
      if (accept) begin
        a_set_q <= i_req_set;
        a_hit_q <= i_req_hit;
        a_way_q <= i_req_way;
        a_row_q <= rd_row;
      end

      o_rsp_valid <= a_valid_q;
      if (a_valid_q) begin
        o_rsp_set  <= a_set_q;
        o_rsp_way  <= tgt_way;
        o_rsp_tags <= new_row_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state_q == S_INIT) begin
        mem_q[init_cnt_q] <= INIT_ROW;
      end else if (a_valid_q) begin
        mem_q[a_set_q] <= new_row_d;
      end
    end
  end

endmodule

// File: tb/tb_lru_state_array.sv
// tb/tb_lru_state_array.sv - directed self-checking bench for lru_state_array (WAY=4, SETS=4)
module tb_lru_state_array;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [1:0] i_req_set;
  logic       i_req_hit;
  logic [1:0] i_req_way;
  logic       o_rsp_valid;
  logic [1:0] o_rsp_set;
  logic [1:0] o_rsp_way;
  logic [7:0] o_rsp_tags;
  logic       o_init_done;

  int checks = 0;
  int errors = 0;

  lru_state_array #(.WAY(4), .SETS(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_set   (i_req_set),
    .i_req_hit   (i_req_hit),
    .i_req_way   (i_req_way),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_set   (o_rsp_set),
    .o_rsp_way   (o_rsp_way),
    .o_rsp_tags  (o_rsp_tags),
    .o_init_done (o_init_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic h, input logic [1:0] w);
    i_req_valid = v;
    i_req_set   = s;
    i_req_hit   = h;
    i_req_way   = w;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] s, input logic [1:0] w, input logic [7:0] t);
    chk({tag, ".valid"}, {31'd0, o_rsp_valid}, 32'd1);
    chk({tag, ".set"},   {30'd0, o_rsp_set},   {30'd0, s});
    chk({tag, ".way"},   {30'd0, o_rsp_way},   {30'd0, w});
    chk({tag, ".tags"},  {24'd0, o_rsp_tags},  {24'd0, t});
  endtask

  task automatic chk_perm(input string tag);
    logic [3:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) mask[o_rsp_tags[2*i +: 2]] = 1'b1;
    chk(tag, {28'd0, mask}, 32'hF);
  endtask

  // Hit way0 (already MRU) on every set: reports each row without altering it.
  task automatic readback_all(input string tag);
    for (int s = 0; s <= 4; s++) begin
      if (s < 4) drive(1'b1, 2'(s), 1'b1, 2'd0);
      else       drive(1'b0, 2'd0, 1'b0, 2'd0);
      step();
      if (s >= 1) chk_rsp(tag, 2'(s-1), 2'd0, 8'hE4);
    end
    step();
    chk({tag, ".idle"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  task automatic single_req(input string tag, input logic [1:0] s, input logic h, input logic [1:0] w,
                            input logic [1:0] exp_w, input logic [7:0] exp_t);
    drive(1'b1, s, h, w);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    chk_rsp(tag, s, exp_w, exp_t);
    step();
    chk({tag, ".strobe"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  task automatic reset_and_init(input string tag);
    i_rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    i_rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    chk({tag, ".init_done"}, {31'd0, o_init_done}, 32'd1);
  endtask

  logic [1:0] il_set [8];
  logic       il_hit [8];
  logic [1:0] il_way [8];
  logic [7:0] il_tag [8];

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    step();
    chk("rst.ready",     {31'd0, o_req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst.rsp_set",   {30'd0, o_rsp_set},   32'd0);
    chk("rst.rsp_way",   {30'd0, o_rsp_way},   32'd0);
    chk("rst.rsp_tags",  {24'd0, o_rsp_tags},  32'd0);
    chk("rst.init_done", {31'd0, o_init_done}, 32'd0);

    // Release reset with a request pending; it must not be accepted during init.
    i_rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 2'd2);
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("init.init_done", {31'd0, o_init_done}, 32'd0);
      chk("init.ready",     {31'd0, o_req_ready}, 32'd0);
      chk("init.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    end
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    chk("init4.init_done", {31'd0, o_init_done}, 32'd1);
    chk("init4.ready",     {31'd0, o_req_ready}, 32'd1);
    chk("init4.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    step();
    chk("init5.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    readback_all("rb0");

    single_req("hit1w2",  2'd1, 1'b1, 2'd2, 2'd2, 8'h9C);
    single_req("miss1a",  2'd1, 1'b0, 2'd0, 2'd3, 8'h4B);
    single_req("miss1b",  2'd1, 1'b0, 2'd3, 2'd1, 8'h36);

    // Back-to-back same-set accesses must chain through the bypass.
    reset_and_init("rst2");
    drive(1'b1, 2'd1, 1'b1, 2'd2);
    step();
    drive(1'b1, 2'd1, 1'b0, 2'd0);
    step();
    chk_rsp("byp0", 2'd1, 2'd2, 8'h9C);
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    chk_rsp("byp1", 2'd1, 2'd3, 8'h4B);
    step();
    chk("byp.idle", {31'd0, o_rsp_valid}, 32'd0);

    il_set = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
    il_hit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    il_way = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    il_tag = '{8'hE4, 8'h93, 8'hE4, 8'h4E, 8'hE4, 8'h39, 8'hE4, 8'hE4};
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, il_set[k], il_hit[k], il_hit[k] ? il_way[k] : 2'd0);
      else       drive(1'b0, 2'd0, 1'b0, 2'd0);
      step();
      if (k >= 1) begin
        chk_rsp("ilv", il_set[k-1], il_way[k-1], il_tag[k-1]);
        chk_perm("ilv.perm");
      end
    end
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    chk("ilv.idle", {31'd0, o_rsp_valid}, 32'd0);

    // Reset while a request sits in stage B: no response, full re-init.
    drive(1'b1, 2'd1, 1'b1, 2'd2);
    step();
    i_rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    chk("mrst.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("mrst.ready",     {31'd0, o_req_ready}, 32'd0);
    chk("mrst.init_done", {31'd0, o_init_done}, 32'd0);
    i_rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("mrst.init.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      chk("mrst.init.init_done", {31'd0, o_init_done}, 32'd0);
    end
    step();
    chk("mrst.done", {31'd0, o_init_done}, 32'd1);
    readback_all("rb1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
